cache_refill_ctrl: RTL and testbench

Miss-refill engine that sits directly upstream of the instruction and data cache blocks.
- Accepts a miss address and fetches the 64-byte line from main memory as 16 × 32-bit beats.
- Assembles the beats into a 512-bit block and presents it, with tag and set, as a one-cycle fill to the cache's block/tag/set/valid load inputs.
- One instance serves the instruction cache and one serves the data cache.

---
 rtl/cache_pkg.sv | 16 +
 rtl/refill_buffer.sv | 28 ++
 rtl/cache_refill_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared field widths, address slice positions and refill FSM states for the
// cache miss-refill engine.
package cache_pkg;
    localparam int TAG_W      = 25;
    localparam int SET_W      = 1;
    localparam int WORD_SEL_W = 4;
    localparam int OFFS_W     = 6;
    localparam int BLOCK_W    = 512;

    // Byte address layout: [31:7] tag, [6] set, [5:2] word, [1:0] byte.
    localparam int TAG_LSB  = 7;
    localparam int SET_LSB  = 6;
    localparam int WORD_LSB = 2;

    typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} refill_state_e;
endpackage

// File: rtl/refill_buffer.sv
// Line assembly register: synchronous clear plus one indexed word write per cycle.
// The next-state value is exported so a completed line can be captured on the last beat.
module refill_buffer #(
    parameter int WORD_W = 32,
    parameter int BEATS  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_clear,
    input  logic                      i_we,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [WORD_W-1:0]         i_data,
    output logic [WORD_W*BEATS-1:0]   o_block_nxt
);
    logic [WORD_W*BEATS-1:0] r_block;

    always_comb begin
        o_block_nxt = r_block;
        if (i_clear)
            o_block_nxt = '0;
        else if (i_we)
            o_block_nxt[i_idx*WORD_W +: WORD_W] = i_data;
    end

    always_ff @(posedge i_clk) begin
        r_block <= o_block_nxt;
    end
endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill engine: one memory request, 16-beat burst assembled into a 512-bit fill.
// Optional CRITICAL_WORD_FIRST_EN: wrap-around burst from the missed word plus early crit_* output.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int BEATS   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_miss_req,
    input  logic [31:0]             i_miss_addr,
    output logic                    o_busy,
    output logic                    o_mem_req,
    output logic [31:0]             o_mem_addr,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [WORD_W-1:0]       i_mem_rdata,
    output logic [WORD_W*BEATS-1:0] o_fill_block,
    output logic [TAG_W-1:0]        o_fill_tag,
    output logic [SET_W-1:0]        o_fill_set,
    output logic                    o_fill_valid,
    output logic                    o_abort
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                    o_crit_valid,
    output logic [WORD_W-1:0]       o_crit_data
`endif
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    refill_state_e           r_state;
    logic [TAG_W-1:0]        r_tag;
    logic [SET_W-1:0]        r_set;
    logic [WORD_SEL_W-1:0]   r_cnt;
    logic [TO_W-1:0]         r_to;
    logic                    r_busy, r_mem_req, r_fill_valid, r_abort;
    logic [31:0]             r_mem_addr;
    logic [WORD_W*BEATS-1:0] r_fill_block;
    logic [TAG_W-1:0]        r_fill_tag;
    logic [SET_W-1:0]        r_fill_set;
    logic [WORD_SEL_W-1:0]   w_start, w_slot;
    logic [WORD_W*BEATS-1:0] w_block_nxt;
    logic                    w_buf_clr, w_buf_we;
    logic                    w_unused_addr;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WORD_SEL_W-1:0]   r_start;
    logic                    r_crit_valid;
    logic [WORD_W-1:0]       r_crit_data;
    assign w_start       = r_start;
    assign o_crit_valid  = r_crit_valid;
    assign o_crit_data   = r_crit_data;
    assign w_unused_addr = ^i_miss_addr[WORD_LSB-1:0];
`else
    assign w_start       = '0;
    assign w_unused_addr = ^i_miss_addr[OFFS_W-1:0];
`endif

    // Buffer is wiped on grant so an aborted burst never leaks into the next line.
    assign w_buf_clr = i_reset | ((r_state == REQ) & i_mem_gnt);
    assign w_buf_we  = (r_state == BURST) & i_mem_rvalid;
    assign w_slot    = w_start + r_cnt;

    refill_buffer #(.WORD_W(WORD_W), .BEATS(BEATS), .IDX_W(WORD_SEL_W)) u_buf (
        .i_clk       (i_clk),
        .i_clear     (w_buf_clr),
        .i_we        (w_buf_we),
        .i_idx       (w_slot),
        .i_data      (i_mem_rdata),
        .o_block_nxt (w_block_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_tag        <= '0;
            r_set        <= '0;
            r_cnt        <= '0;
            r_to         <= '0;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_fill_block <= '0;
            r_fill_tag   <= '0;
            r_fill_set   <= '0;
            r_fill_valid <= 1'b0;
            r_abort      <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_start      <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
`endif
        end else begin
            r_fill_valid <= 1'b0;
            r_abort      <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_crit_valid <= 1'b0;
`endif
            case (r_state)
                IDLE: if (i_miss_req) begin
                    r_tag     <= i_miss_addr[31:TAG_LSB];
                    r_set     <= i_miss_addr[SET_LSB +: SET_W];
                    r_mem_req <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= REQ;
`ifdef CRITICAL_WORD_FIRST_EN
                    r_start    <= i_miss_addr[WORD_LSB +: WORD_SEL_W];
                    r_mem_addr <= {i_miss_addr[31:WORD_LSB], WORD_LSB'(0)};
`else
                    r_mem_addr <= {i_miss_addr[31:OFFS_W], OFFS_W'(0)};
`endif
                end
                REQ: if (i_mem_gnt) begin
                    r_mem_req <= 1'b0;
                    r_cnt     <= '0;
                    r_to      <= '0;
                    r_state   <= BURST;
                end
                BURST: begin
                    if (i_mem_rvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_to  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
                        if (r_cnt == '0) begin
                            r_crit_valid <= 1'b1;
                            r_crit_data  <= i_mem_rdata;
                        end
`endif
                        if (r_cnt == WORD_SEL_W'(BEATS - 1)) begin
                            r_fill_block <= w_block_nxt;
                            r_fill_tag   <= r_tag;
                            r_fill_set   <= r_set;
                            r_fill_valid <= 1'b1;
                            r_state      <= DONE;
                        end
                    end else if (r_to == TO_W'(TIMEOUT - 1)) begin
                        r_abort <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_fill_block = r_fill_block;
    assign o_fill_tag   = r_fill_tag;
    assign o_fill_set   = r_fill_set;
    assign o_fill_valid = r_fill_valid;
    assign o_abort      = r_abort;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: vector table, corner sequences, random refills.
// Build with CRITICAL_WORD_FIRST_EN to also exercise the critical-word-first path.
module tb_cache_refill_ctrl;
    localparam int TO    = 8;
    localparam int BEATS = 16;

    logic         clk = 1'b0;
    logic         reset, miss_req, mem_gnt, mem_rvalid;
    logic [31:0]  miss_addr, mem_rdata;
    logic         busy, mem_req, fill_valid, abort;
    logic [31:0]  mem_addr;
    logic [511:0] fill_block;
    logic [24:0]  fill_tag;
    logic [0:0]   fill_set;
`ifdef CRITICAL_WORD_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.WORD_W(32), .BEATS(BEATS), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_miss_req   (miss_req),
        .i_miss_addr  (miss_addr),
        .o_busy       (busy),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_fill_block (fill_block),
        .o_fill_tag   (fill_tag),
        .o_fill_set   (fill_set),
        .o_fill_valid (fill_valid),
        .o_abort      (abort)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .o_crit_valid (crit_valid),
        .o_crit_data  (crit_data)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          gnt_dly;
        int          gap;
        logic [31:0] base;
        logic [24:0] tag;
        logic        set;
        int          cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory-side model: issues a miss, stalls the grant, streams beats base+i.
    // stop<16 stops the burst early and expects a timeout abort instead of a fill.
    task automatic refill(input logic [31:0] addr, input int gnt_dly, input int gap,
                          input int stop, input logic noise, input logic hold,
                          input logic [31:0] addr2, input logic [31:0] base,
                          input logic [24:0] etag, input logic eset, input int ecyc);
        logic [511:0] eblk;
        logic [31:0]  emaddr;
        int           start, cyc, busy_lo, fills, found, k;
`ifdef CRITICAL_WORD_FIRST_EN
        start  = (addr / 4) % 16;
        emaddr = addr & 32'hFFFF_FFFC;
`else
        start  = 0;
        emaddr = addr & 32'hFFFF_FFC0;
`endif
        eblk = '0;
        for (int i = 0; i < BEATS; i++)
            eblk[((start + i) % BEATS) * 32 +: 32] = base + i;
        busy_lo = 0;
        fills   = 0;

        miss_addr = addr;
        miss_req  = 1'b1;
        tick();
        cyc = 1;
        if (hold) miss_addr = addr2;
        else      miss_req  = 1'b0;
        chk("busy_on", busy, 1);
        chk("mem_req_on", mem_req, 1);
        chk("mem_addr", mem_addr, emaddr);

        for (int s = 0; s < gnt_dly; s++) begin
            if (noise) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
            tick();
            cyc++;
            chk("req_stall", {mem_req, busy, mem_addr}, {2'b11, emaddr});
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        tick();
        cyc++;
        mem_gnt = 1'b0;
        chk("req_drop", mem_req, 0);

        for (int b = 0; b < stop; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + b;
            if (noise) mem_gnt = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            chk("crit_valid", crit_valid, (b == 0));
            if (b == 0) chk("crit_data", crit_data, base);
`endif
            if (b < stop - 1) begin
                busy_lo += !busy;
                fills   += fill_valid;
                for (int g = 0; g < gap; g++) begin
                    if (noise) mem_rdata = $urandom;
                    tick();
                    cyc++;
                    busy_lo += !busy;
                    fills   += fill_valid;
                end
            end
        end

        if (stop == BEATS) begin
            chk("fill_valid", fill_valid, 1);
            chk("fill_cycle", cyc + 1, ecyc);
            chk("fill_block", fill_block, eblk);
            chk("fill_tag", fill_tag, etag);
            chk("fill_set", fill_set, eset);
            chk("busy_in_fill", busy, 1);
            chk("busy_gap", busy_lo, 0);
            chk("early_fill", fills, 0);
            if (noise) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
            tick();
            mem_rvalid = 1'b0;
            chk("fill_pulse", {fill_valid, busy}, 0);
            chk("fill_hold", fill_block, eblk);
        end else begin
            found = 0;
            k     = 0;
            while (found == 0 && k < TO + 4) begin
                tick();
                k++;
                fills += fill_valid;
                if (abort) found = k;
            end
            chk("abort_delay", found, TO);
            chk("abort_state", {busy, mem_req, fill_valid}, 0);
            chk("abort_nofill", fills, 0);
            tick();
            chk("abort_pulse", abort, 0);
        end
    endtask

    initial begin
        vec_t        tbl[5];
        logic [31:0] a, bs;
        int          gd, gp;

        tbl[0] = '{32'h0000_1A40, 0, 0, 32'h0000_0100, 25'h000034,   1'b1, 19};
        tbl[1] = '{32'h0000_1A40, 5, 0, 32'h0000_0200, 25'h000034,   1'b1, 24};
        tbl[2] = '{32'h8000_0000, 0, 3, 32'h0000_A000, 25'h1000000,  1'b0, 64};
        tbl[3] = '{32'hFFFF_FFFF, 2, 1, 32'hDEAD_0000, 25'h1FFFFFF,  1'b1, 36};
        tbl[4] = '{32'h0000_1A40, 0, 0, 32'h0000_0100, 25'h000034,   1'b1, 19};

        reset = 1'b1; miss_req = 1'b0; miss_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        chk("rst_state", {busy, mem_req, mem_addr, fill_valid, abort, fill_set, fill_tag}, 0);
        chk("rst_block", fill_block, 0);
        reset = 1'b0;

        // stray memory handshakes while idle
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("idle_stray", {busy, mem_req, fill_valid, abort}, 0);

        foreach (tbl[i])
            refill(tbl[i].addr, tbl[i].gnt_dly, tbl[i].gap, BEATS, 1'b0, 1'b0, '0,
                   tbl[i].base, tbl[i].tag, tbl[i].set, tbl[i].cyc);
        chk("word0", fill_block[31:0], 32'h100);
        chk("word15", fill_block[511:480], 32'h10F);

        // timeout after beat 7
        refill(32'h0000_2000, 0, 0, 7, 1'b0, 1'b0, '0, 32'h300, 25'h40, 1'b0, 0);
        chk("abort_keeps_fill", fill_block[31:0], 32'h100);

        // reset in the middle of a burst
        miss_addr = 32'h0000_4080; miss_req = 1'b1;
        tick();
        miss_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int b = 0; b < 5; b++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_0000 + b;
            tick();
        end
        mem_rvalid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid", {busy, mem_req, fill_valid, abort}, 0);
        chk("rst_mid_block", fill_block, 0);
        refill(32'h0000_4080, 1, 0, BEATS, 1'b0, 1'b0, '0, 32'h500, 25'h81, 1'b0, 20);

        // miss held through a busy refill and across fill_valid
        refill(32'h0000_0100, 2, 1, BEATS, 1'b0, 1'b1, 32'h0001_2340, 32'h600, 25'h2, 1'b0, 36);
        chk("hold_idle", {busy, miss_req}, 2'b01);
        refill(32'h0001_2340, 0, 0, BEATS, 1'b0, 1'b0, '0, 32'h700, 25'h246, 1'b1, 19);

`ifdef CRITICAL_WORD_FIRST_EN
        refill(32'h0000_0034, 0, 0, BEATS, 1'b0, 1'b0, '0, 32'hA0, 25'h0, 1'b0, 19);
        chk("slot13", fill_block[13*32 +: 32], 32'hA0);
        chk("slot14", fill_block[14*32 +: 32], 32'hA1);
        chk("slot0",  fill_block[31:0],        32'hA3);
        chk("slot12", fill_block[12*32 +: 32], 32'hAF);
`endif

        // random refills with spurious handshakes sprinkled in
        for (int r = 0; r < 20; r++) begin
            a  = $urandom;
            bs = $urandom;
            gd = $urandom_range(0, 3);
            gp = $urandom_range(0, 3);
            refill(a, gd, gp, BEATS, 1'b1, 1'b0, '0, bs, 25'(a / 128), 1'((a / 64) % 2),
                   19 + gd + 15 * gp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
